// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a one-entry skid, synchronous flush and occupancy count.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble cycle counters.
module pipe_stage_buf #(
   parameter int                 DATA_W = 32,
   parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [1:0]        o_count
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       o_stall_cycles,
   output logic [31:0]       o_bubble_cycles
`endif
);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic              r_vld_p0;
   logic [DATA_W-1:0] r_data_p0;
   logic              r_vld_p1;
   logic [DATA_W-1:0] r_data_p1;
   logic [1:0]        r_count;

   logic              w_vld_p0_nxt;
   logic [DATA_W-1:0] w_data_p0_nxt;
   logic              w_vld_p1_nxt;
   logic [DATA_W-1:0] w_data_p1_nxt;
   logic              w_accept;
   logic              w_consume;

   assign o_in_ready  = ~r_vld_p1;
   assign o_out_valid = r_vld_p0;
   assign o_out_data  = r_data_p0;
   assign o_count     = r_count;

   assign w_accept  = i_in_valid & ~r_vld_p1;
   assign w_consume = r_vld_p0 & i_out_ready;

   always_comb begin
      w_vld_p0_nxt  = r_vld_p0;
      w_data_p0_nxt = r_data_p0;
      w_vld_p1_nxt  = r_vld_p1;
      w_data_p1_nxt = r_data_p1;
      if (i_flush) begin
         w_vld_p0_nxt  = 1'b0;
         w_data_p0_nxt = BUBBLE;
         w_vld_p1_nxt  = 1'b0;
         w_data_p1_nxt = BUBBLE;
      end else if (!r_vld_p1) begin
         if (w_accept) begin
            if (!r_vld_p0 || i_out_ready) begin
               w_vld_p0_nxt  = 1'b1;
               w_data_p0_nxt = i_in_data;
            end else begin
               w_vld_p1_nxt  = 1'b1;
               w_data_p1_nxt = i_in_data;
            end
         end else if (w_consume) begin
            w_vld_p0_nxt  = 1'b0;
            w_data_p0_nxt = BUBBLE;
         end
      end else if (w_consume) begin
         // Skid is full: it refills the head as soon as the head drains.
         w_data_p0_nxt = r_data_p1;
         w_vld_p1_nxt  = 1'b0;
         w_data_p1_nxt = BUBBLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_vld_p0  <= 1'b0;
         r_data_p0 <= BUBBLE;
         r_vld_p1  <= 1'b0;
         r_data_p1 <= BUBBLE;
         r_count   <= 2'd0;
      end else begin
         r_vld_p0  <= w_vld_p0_nxt;
         r_data_p0 <= w_data_p0_nxt;
         r_vld_p1  <= w_vld_p1_nxt;
         r_data_p1 <= w_data_p1_nxt;
         r_count   <= {1'b0, w_vld_p0_nxt} + {1'b0, w_vld_p1_nxt};
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_bubble_cycles;

   assign o_stall_cycles  = r_stall_cycles;
   assign o_bubble_cycles = r_bubble_cycles;

   // Flush does not touch these; only reset clears them.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_stall_cycles  <= 32'd0;
         r_bubble_cycles <= 32'd0;
      end else begin
         if (r_vld_p0 && !i_out_ready)
            r_stall_cycles <= sat_inc(r_stall_cycles);
         if (!r_vld_p0 && i_out_ready)
            r_bubble_cycles <= sat_inc(r_bubble_cycles);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a FIFO-of-payloads model, directed scenarios, then random traffic.
module tb_pipe_stage_buf;
   localparam int              DW  = 16;
   localparam logic [DW-1:0]   BUB = 16'hDEAD;

   logic          clk;
   logic          i_reset, i_flush, i_in_valid, i_out_ready;
   logic [DW-1:0] i_in_data;
   logic          o_in_ready, o_out_valid;
   logic [DW-1:0] o_out_data;
   logic [1:0]    o_count;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   o_stall_cycles, o_bubble_cycles;
   int            m_stall, m_bubble;
`endif

   pipe_stage_buf #(.DATA_W(DW), .BUBBLE(BUB)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_count(o_count)
`ifdef PIPE_STAGE_PERF_EN
      , .o_stall_cycles(o_stall_cycles), .o_bubble_cycles(o_bubble_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entries the stage should be holding, oldest first.
   logic [DW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: checks visible state against the model, pops on every downstream handshake.
   always @(negedge clk) begin
      if (i_reset === 1'b1) begin
         check("count",     {30'd0, o_count},     exp_q.size());
         check("in_ready",  {31'd0, o_in_ready},  (exp_q.size() < 2) ? 1 : 0);
         check("out_valid", {31'd0, o_out_valid}, (exp_q.size() > 0) ? 1 : 0);
         check("out_data",  {16'd0, o_out_data},  {16'd0, (exp_q.size() > 0) ? exp_q[0] : BUB});
`ifdef PIPE_STAGE_PERF_EN
         check("stall_cycles",  o_stall_cycles,  m_stall);
         check("bubble_cycles", o_bubble_cycles, m_bubble);
         if (exp_q.size() > 0 && !i_out_ready) m_stall++;
         if (exp_q.size() == 0 && i_out_ready) m_bubble++;
`endif
         if (o_out_valid === 1'b1 && i_out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected none at %0t", o_out_data, $time);
            end else begin
               void'(exp_q.pop_front());
            end
         end
      end else begin
`ifdef PIPE_STAGE_PERF_EN
         m_stall  = 0;
         m_bubble = 0;
`endif
      end
   end

   // One clock of stimulus; the model is updated once the edge has been taken.
   task automatic step(input bit rst, input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
      bit acc;
      i_reset     = rst;
      i_in_valid  = v;
      i_in_data   = d;
      i_out_ready = rdy;
      i_flush     = fl;
      acc = v && (exp_q.size() < 2);
      @(posedge clk);
      if (!rst || fl) exp_q.delete();
      else if (acc)   exp_q.push_back(d);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(0, 1, 16'h0055, 1, 0);
      step(1, 0, 16'h0000, 0, 0);
      step(1, 0, 16'h0000, 0, 0);

      step(1, 1, 16'h0011, 1, 0);
      step(1, 1, 16'h0022, 1, 0);
      step(1, 1, 16'h0033, 1, 0);
      step(1, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 1, 0);

      step(1, 1, 16'h00A1, 0, 0);
      step(1, 1, 16'h00A2, 0, 0);
      step(1, 1, 16'h00A9, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0000, 1, 0);

      step(1, 1, 16'h00B1, 0, 0);
      step(1, 1, 16'h00B2, 0, 0);
      step(1, 1, 16'h00B3, 0, 1);
      step(1, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 1, 0);

      step(1, 1, 16'h00C1, 1, 0);
      step(1, 0, 16'h0000, 1, 1);
      step(1, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 1, 0);

      for (int i = 0; i < 5; i++) step(1, (i == 0), 16'h0077, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 0, 1);
      step(1, 0, 16'h0000, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 3) != 0),
              DW'($urandom),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 19) == 0));
      end
      step(1, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, width-parametrised pipeline buffer register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB payload registers; each stage instantiates one with its packed struct as payload.
- Adds stall back-pressure at full throughput, synchronous flush with bubble insertion, and an occupancy report.

Parameters:
- DATA_W, 32: payload width in bits; stages pass $bits of their stage struct.
- BUBBLE, '0: payload value presented when the stage is empty or flushed (a NOP/control-zero encoding).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; equals !skid_valid, register-driven, no combinational path from out_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  head payload; BUBBLE when out_valid=0.
- count  out  2  entries held, 0..2.

Behaviour:
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- State is the main register (out_valid, out_data), the skid register (skid_valid, skid_data) and count.
- Priority per edge: reset (reset==0) > flush > normal.
- Reset values: out_valid=0, out_data=BUBBLE, skid_valid=0, skid_data=BUBBLE, count=0, in_ready=1 from the first cycle after reset is released. Inputs are ignored while reset==0.
- Flush: out_valid=0, skid_valid=0, both data registers=BUBBLE, count=0.
  - An accept in the flush cycle is completed from the upstream view but the payload is discarded.
  - A consume in the flush cycle is still valid downstream.
- Normal, skid empty:
  - accept with (!out_valid | out_ready): main <= in_data, out_valid=1. Pass-through, latency 1 cycle.
  - accept with out_valid & !out_ready: skid <= in_data, skid_valid=1. in_ready falls on the next cycle.
  - no accept with consume: out_valid=0, out_data <= BUBBLE.
- Normal, skid full (in_ready=0, no accept possible):
  - consume: main <= skid_data, skid_valid=0, skid_data <= BUBBLE.
  - no consume: hold.
- count = out_valid + skid_valid. The skid is never valid while main is empty.
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Throughput is 1 payload/cycle when out_ready stays high.
- Only payloads in flight at the edge are lost on flush.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cycles [31:0] and bubble_cycles [31:0].
  - stall_cycles increments when out_valid & !out_ready.
  - bubble_cycles increments when !out_valid & out_ready.
  - Both saturate at 32'hFFFF_FFFF, are cleared by reset only and are unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset held low 3 cycles, then released -> out_valid=0, out_data=BUBBLE, count=0, in_ready=1; in_valid=1 during reset is not captured.
- Streaming: out_ready=1, in_data=0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, count stays 1, in_ready stays 1.
- Back-pressure: out_ready=0, send 0xA1 then 0xA2 -> count=2, in_ready=0, out_data=0xA1 held. Raise out_ready -> 0xA1 consumed, then 0xA2, count 2→1→0, in_ready=1 one cycle after the skid drains.
- Flush while full (0xB1 main, 0xB2 skid) with in_valid=1, in_data=0xB3 -> next cycle out_valid=0, out_data=BUBBLE, count=0, 0xB3 never appears.
- Flush simultaneous with consume of 0xC1 -> 0xC1 seen once downstream; nothing follows.
- PIPE_STAGE_PERF_EN: 5 cycles out_valid=1/out_ready=0 then 3 cycles empty with out_ready=1 -> stall_cycles=5, bubble_cycles=3; unchanged after flush, 0 after reset.
